// File: rtl/vme_rd_pkg.sv
// Shared encodings for the VME read sequencer: FSM states, transfer size codes,
// byte counts and the request legality rule.
package vme_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [1:0] SZ_D08 = 2'b00;
    localparam logic [1:0] SZ_D16 = 2'b01;
    localparam logic [1:0] SZ_D32 = 2'b10;
    localparam logic [1:0] SZ_ILL = 2'b11;

    localparam logic [2:0] NB_D08 = 3'd1;
    localparam logic [2:0] NB_D16 = 3'd2;
    localparam logic [2:0] NB_D32 = 3'd4;

    // D16 must start on an even lane and D32 on lane 0 so no transfer wraps the word.
    function automatic logic req_legal(input logic [1:0] size, input logic [1:0] lane);
        logic ok;
        ok = 1'b0;
        case (size)
            SZ_D08:  ok = 1'b1;
            SZ_D16:  ok = ~lane[0];
            SZ_D32:  ok = (lane == 2'd0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [2:0] byte_count(input logic [1:0] size);
        logic [2:0] n;
        n = NB_D08;
        case (size)
            SZ_D16:  n = NB_D16;
            SZ_D32:  n = NB_D32;
            default: n = NB_D08;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/vme_rd_seq.sv
// VME read sequencer: walks an external 4:1 byte mux across the requested lanes,
// waiting a settle time per lane, and assembles the bytes into a 32-bit word.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_IDLE    | waiting for req; mux parked on select 11
//   ST_SETTLE  | mux driving current lane, settle down-counter running
//   ST_CAPTURE | latch mux_din into the current lane of rdata, advance lane
//   ST_DONE    | one-cycle completion, rdata valid and held
module vme_rd_seq
    import vme_rd_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        abort,
    output logic [1:0]  mux_sel,
    input  logic [7:0]  mux_din,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata
);

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  settle_cnt;
    logic [1:0]  cur_lane;
    logic [2:0]  nbytes;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        idle_req;
    logic        accept;

    assign idle_req = (state == ST_IDLE) && req && !abort;
    assign accept   = idle_req && req_legal(size, lane);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (abort)                 state_nxt = ST_IDLE;
                else if (settle_cnt <= 4'd1) state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (abort)               state_nxt = ST_IDLE;
                else if (nbytes == 3'd1) state_nxt = ST_DONE;
                else                     state_nxt = ST_SETTLE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle_cnt <= 4'd0;
            cur_lane   <= 2'd0;
            nbytes     <= 3'd0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            err_q <= idle_req && !req_legal(size, lane);
            if (state != ST_IDLE && abort) begin
                settle_cnt <= 4'd0;
                nbytes     <= 3'd0;
                rdata_q    <= 32'd0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            cur_lane   <= lane;
                            nbytes     <= byte_count(size);
                            settle_cnt <= SETTLE_LD;
                            rdata_q    <= 32'd0;
                        end
                    end
                    ST_SETTLE: begin
                        if (settle_cnt > 4'd1) settle_cnt <= settle_cnt - 4'd1;
                    end
                    ST_CAPTURE: begin
                        rdata_q[{cur_lane, 3'b000} +: 8] <= mux_din;
                        cur_lane   <= cur_lane + 2'd1;
                        nbytes     <= nbytes - 3'd1;
                        settle_cnt <= SETTLE_LD;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        busy    = (state != ST_IDLE);
        done    = (state == ST_DONE);
        mux_sel = 2'b11;
        if (state == ST_SETTLE || state == ST_CAPTURE) mux_sel = 2'd3 - cur_lane;
    end

    assign err   = err_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_vme_rd_seq.sv
// Bench for vme_rd_seq: two instances (SETTLE=1 and SETTLE=3) driven independently,
// checked against an arithmetic timing/data model of each transfer.
module tb_vme_rd_seq;

    localparam logic [1:0] D08 = 2'b00;
    localparam logic [1:0] D16 = 2'b01;
    localparam logic [1:0] D32 = 2'b10;
    localparam logic [1:0] ILL = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_v     [2];
    logic        abort_v   [2];
    logic [1:0]  size_v    [2];
    logic [1:0]  lane_v    [2];
    logic [1:0]  mux_sel_v [2];
    logic [7:0]  mux_din_v [2];
    logic        busy_v    [2];
    logic        done_v    [2];
    logic        err_v     [2];
    logic [31:0] rdata_v   [2];

    logic [7:0]  mem [4];
    logic [31:0] exp_rdata [2];
    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign mux_din_v[0] = mem[3 - int'(mux_sel_v[0])];
    assign mux_din_v[1] = mem[3 - int'(mux_sel_v[1])];

    vme_rd_seq #(.SETTLE(1)) dut_s1 (
        .clk(clk), .reset(reset), .req(req_v[0]), .size(size_v[0]), .lane(lane_v[0]),
        .abort(abort_v[0]), .mux_sel(mux_sel_v[0]), .mux_din(mux_din_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0]), .rdata(rdata_v[0])
    );

    vme_rd_seq #(.SETTLE(3)) dut_s3 (
        .clk(clk), .reset(reset), .req(req_v[1]), .size(size_v[1]), .lane(lane_v[1]),
        .abort(abort_v[1]), .mux_sel(mux_sel_v[1]), .mux_din(mux_din_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1]), .rdata(rdata_v[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int settle_of(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    function automatic bit legal_m(input logic [1:0] sz, input logic [1:0] ln);
        if (sz == D08) return 1'b1;
        if (sz == D16) return (ln == 2'd0 || ln == 2'd2);
        if (sz == D32) return (ln == 2'd0);
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_word(input logic [1:0] sz, input logic [1:0] ln);
        logic [31:0] w;
        int l;
        w = 32'd0;
        for (int i = 0; i < (1 << sz); i++) begin
            l = (int'(ln) + i) % 4;
            w[l*8 +: 8] = mem[l];
        end
        return w;
    endfunction

    task automatic idle_outputs(input int u, input string tag, input logic [31:0] rd);
        chk({tag, "_busy"}, busy_v[u], 0);
        chk({tag, "_done"}, done_v[u], 0);
        chk({tag, "_err"}, err_v[u], 0);
        chk({tag, "_mux"}, mux_sel_v[u], 3);
        chk({tag, "_rdata"}, rdata_v[u], rd);
    endtask

    // Called at a negedge; returns at a negedge with the instance idle.
    task automatic xfer(input int u, input logic [1:0] sz, input logic [1:0] ln, input bit junk);
        int s, n, d;
        logic [31:0] w;
        s = settle_of(u);
        req_v[u] = 1'b1; size_v[u] = sz; lane_v[u] = ln;
        @(posedge clk); @(negedge clk);
        req_v[u] = 1'b0;
        if (!legal_m(sz, ln)) begin
            chk("err_pulse", err_v[u], 1);
            chk("err_busy", busy_v[u], 0);
            chk("err_rdata", rdata_v[u], exp_rdata[u]);
            @(negedge clk);
            chk("err_once", err_v[u], 0);
            chk("err_rdata_hold", rdata_v[u], exp_rdata[u]);
            return;
        end
        n = 1 << sz;
        d = n * (s + 1);
        w = exp_word(sz, ln);
        for (int j = 0; j <= d + 1; j++) begin
            if (j < d) begin
                chk("xfer_busy", busy_v[u], 1);
                chk("xfer_done_early", done_v[u], 0);
                chk("xfer_err", err_v[u], 0);
                chk("xfer_mux", mux_sel_v[u], 3 - ((int'(ln) + j / (s + 1)) % 4));
            end else if (j == d) begin
                chk("xfer_done", done_v[u], 1);
                chk("xfer_done_busy", busy_v[u], 1);
                chk("xfer_rdata", rdata_v[u], w);
            end else begin
                idle_outputs(u, "xfer_after", w);
            end
            if (j <= d) begin
                if (junk && j < d) begin
                    req_v[u]  = 1'($urandom_range(0, 1));
                    size_v[u] = 2'($urandom_range(0, 3));
                    lane_v[u] = 2'($urandom_range(0, 3));
                end else begin
                    req_v[u] = 1'b0;
                end
                @(negedge clk);
            end
        end
        req_v[u] = 1'b0;
        exp_rdata[u] = w;
    endtask

    // Abort raised after sample k (0..d-1) of a legal transfer.
    task automatic xfer_abort(input int u, input logic [1:0] sz, input logic [1:0] ln, input int k);
        req_v[u] = 1'b1; size_v[u] = sz; lane_v[u] = ln;
        @(posedge clk); @(negedge clk);
        req_v[u] = 1'b0;
        for (int j = 0; j < k; j++) begin
            chk("abort_pre_done", done_v[u], 0);
            @(negedge clk);
        end
        chk("abort_pre_busy", busy_v[u], 1);
        abort_v[u] = 1'b1;
        @(negedge clk);
        abort_v[u] = 1'b0;
        exp_rdata[u] = 32'd0;
        idle_outputs(u, "abort_now", 32'd0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("abort_no_done", done_v[u], 0);
            chk("abort_idle", busy_v[u], 0);
        end
    endtask

    initial begin
        int u, k, d;
        logic [1:0] sz, ln;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_v[i] = 1'b0; abort_v[i] = 1'b0; size_v[i] = 2'd0; lane_v[i] = 2'd0;
            exp_rdata[i] = 32'd0;
        end
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        @(negedge clk); @(negedge clk);
        idle_outputs(0, "reset_s1", 32'd0);
        idle_outputs(1, "reset_s3", 32'd0);

        // Released at a negedge; request accepted on the very next rising edge.
        reset = 1'b0;
        xfer(0, D32, 2'd0, 1'b0);
        chk("d32_word", exp_rdata[0], 32'h44332211);
        xfer(0, D16, 2'd2, 1'b0);
        chk("d16_word", exp_rdata[0], 32'h44330000);
        xfer(1, D08, 2'd3, 1'b0);
        chk("d08_s3_word", exp_rdata[1], 32'h44000000);

        xfer(0, D32, 2'd1, 1'b0);
        xfer(0, ILL, 2'd0, 1'b0);
        xfer(0, D16, 2'd1, 1'b0);

        xfer_abort(0, D32, 2'd0, 2);
        xfer(0, D08, 2'd0, 1'b0);
        chk("after_abort_word", rdata_v[0], 32'h00000011);
        xfer_abort(1, D16, 2'd0, 5);

        // abort and req together in idle: nothing happens
        req_v[0] = 1'b1; abort_v[0] = 1'b1; size_v[0] = D32; lane_v[0] = 2'd1;
        @(posedge clk); @(negedge clk);
        req_v[0] = 1'b0; abort_v[0] = 1'b0;
        idle_outputs(0, "abort_req_idle", exp_rdata[0]);
        @(negedge clk);
        idle_outputs(0, "abort_req_idle2", exp_rdata[0]);

        for (int it = 0; it < 40; it++) begin
            u  = int'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            ln = 2'($urandom_range(0, 3));
            for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
            if (legal_m(sz, ln) && $urandom_range(0, 3) == 0) begin
                d = (1 << sz) * (settle_of(u) + 1);
                k = int'($urandom_range(0, d - 1));
                xfer_abort(u, sz, ln, k);
            end else begin
                xfer(u, sz, ln, 1'b1);
            end
        end

        // reset mid-transfer on both instances
        for (int i = 0; i < 2; i++) begin
            req_v[i] = 1'b1; size_v[i] = D32; lane_v[i] = 2'd0;
        end
        @(posedge clk); @(negedge clk);
        req_v[0] = 1'b0; req_v[1] = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("pre_reset_busy", busy_v[1], 1);
        reset = 1'b1;
        #1;
        idle_outputs(0, "mid_reset_s1", 32'd0);
        idle_outputs(1, "mid_reset_s3", 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            chk("post_reset_done_s1", done_v[0], 0);
            chk("post_reset_done_s3", done_v[1], 0);
            chk("post_reset_busy", busy_v[0] | busy_v[1], 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vme_rd_seq.md
VME_RD_SEQ -- requirements
Module: vme_rd_seq

Interface
REQ-001 SHALL have parameter SETTLE, default 1, mux settle cycles per byte lane (legal 1..15).
REQ-002 SHALL have one clock; reset is asynchronous and active-high; ports clk and reset.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  1  read request, sampled only while busy=0.
REQ-006 size  input  2  transfer size: 00 D08, 01 D16, 10 D32, 11 illegal.
REQ-007 lane  input  2  starting byte lane (0 = LSB byte).
REQ-008 abort  input  1  terminate the transfer in progress.
REQ-009 mux_sel  output  2  select to external 4:1 byte mux; lane n selected by mux_sel = 3-n.
REQ-010 mux_din  input  8  byte returned by external mux.
REQ-011 busy  output  1  transfer in progress.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 err  output  1  one-cycle illegal-request pulse.
REQ-014 rdata  output  32  assembled read word.

Function
REQ-015 States SHALL be IDLE, SETTLE, CAPTURE, DONE.
REQ-016 IDLE: busy=0, mux_sel=2'b11; req=1 with legal size/lane -> SETTLE, latch lane, byte count N=1/2/4, clear rdata to 0.
REQ-017 Illegal request (size=11, D16 with odd lane, D32 with lane!=0) SHALL pulse err for one cycle, remain IDLE, leave rdata unchanged.
REQ-018 SETTLE: mux_sel = 3-current lane, held SETTLE cycles via down-counter, then -> CAPTURE.
REQ-019 CAPTURE (1 cycle, mux_sel unchanged): rdata[8*lane+7:8*lane] <= mux_din; lane +1 (2-bit); N -1; N reaches 0 -> DONE, else -> SETTLE.
REQ-020 DONE: done=1, busy=1 for exactly one cycle, then IDLE.
REQ-021 busy SHALL be 1 in SETTLE, CAPTURE, DONE.
REQ-022 done SHALL assert N*(SETTLE+1) cycles after the accepting edge (D32, SETTLE=1: 8 cycles).
REQ-023 rdata bytes not captured SHALL read 0; rdata SHALL hold stable from DONE until the next accepted request.
REQ-024 req while busy=1 SHALL be ignored (no queueing, no err).
REQ-025 abort in SETTLE/CAPTURE/DONE SHALL force IDLE next cycle, suppress done, clear rdata to 0.
REQ-026 abort and req together in IDLE: abort wins, request dropped, no err.
REQ-027 Settle counter width SHALL be 4 bits; lane arithmetic wraps mod 4 (never exercised by legal requests).

Reset
REQ-028 reset=1 SHALL asynchronously force IDLE, mux_sel=2'b11, busy=0, done=0, err=0, rdata=0, counters 0.
REQ-029 reset mid-transfer SHALL discard the transfer with no done pulse after release.
REQ-030 First req accepted on the first rising edge after reset deasserts.

Structure
REQ-031 Package vme_rd_pkg SHALL hold state encoding, size codes (SZ_D08, SZ_D16, SZ_D32, SZ_ILL) and byte-count constants.
REQ-032 No sub-module; the byte mux stays external, connected through mux_sel/mux_din in the parent slave.

Verification (mux model: lane0=8'h11, lane1=8'h22, lane2=8'h33, lane3=8'h44; SETTLE=1)
REQ-033 D32 lane0 -> mux_sel 11,10,01,00; done 8 cycles after accept; rdata=32'h44332211.
REQ-034 D16 lane2 -> mux_sel 01,00; done after 4 cycles; rdata=32'h44330000.
REQ-035 D08 lane3 with SETTLE=3 -> mux_sel 00 for 4 cycles; done after 4 cycles; rdata=32'h44000000.
REQ-036 D32 lane1, then size=11 -> err one-cycle pulse each, busy stays 0, rdata unchanged.
REQ-037 D32 lane0, abort 3 cycles after accept -> busy 0 next cycle, no done, rdata=0; new D08 lane0 then yields 32'h00000011.
REQ-038 reset asserted mid-D32 -> all outputs reset values immediately, no done after release.
